// File: rtl/i2c_pkg.sv
// Shared I2C constants, state encodings and register-address width.
// Define I2C_WRITE_REG16_EN to use 16-bit register addresses, sent MSB first.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_BUS_CHECK = 4'd1,
    S_CMD       = 4'd2,
    S_ADDR      = 4'd3,
    S_FETCH     = 4'd4,
    S_SEND      = 4'd5,
    S_DRAIN     = 4'd6,
    S_DONE      = 4'd7,
    S_FAIL      = 4'd8
  } state_t;

  localparam logic [6:0]  VL53L0X_ADDR             = 7'h29;
  localparam int unsigned TIMEOUT_CYCLES_DEF       = 27000;
  localparam int unsigned DRAIN_TIMEOUT_CYCLES_DEF = 270000;
  localparam int unsigned MAX_BYTES                = 16;
  localparam int unsigned CNT_W                    = 32;
  localparam int unsigned BCNT_W                   = 5;

`ifdef I2C_WRITE_REG16_EN
  localparam int unsigned REG_W = 16;
`else
  localparam int unsigned REG_W = 8;
`endif
  localparam int unsigned ADDR_BYTES = REG_W / 8;

endpackage

// File: rtl/i2c_timeout_ctr.sv
// Per-state cycle counter; expired rises once the count reaches limit-1,
// so the owning FSM leaves the state exactly limit cycles after entering it.
module i2c_timeout_ctr
  import i2c_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired = (limit != '0) && (count_q >= (limit - CNT_W'(1)));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (!expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/i2c_write_reg_burst.sv
// I2C register-write initiator: START, dev+W, register address, payload, STOP.
// Define I2C_WRITE_REG16_EN for a two-byte register address.
module i2c_write_reg_burst
  import i2c_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES       = TIMEOUT_CYCLES_DEF,
  parameter int unsigned DRAIN_TIMEOUT_CYCLES = DRAIN_TIMEOUT_CYCLES_DEF,
  parameter int unsigned MAX_PAYLOAD          = i2c_pkg::MAX_BYTES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [6:0]        dev_address,
  input  logic [REG_W-1:0]  reg_address,
  input  logic [BCNT_W-1:0] byte_count,
  input  logic [7:0]        wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              done,
  output logic              busy,
  output logic              message_failure,
  output logic [3:0]        state_out,
  output logic [6:0]        i2c_cmd_address,
  output logic              i2c_cmd_start,
  output logic              i2c_cmd_read,
  output logic              i2c_cmd_write,
  output logic              i2c_cmd_write_multiple,
  output logic              i2c_cmd_stop,
  output logic              i2c_cmd_valid,
  input  logic              i2c_cmd_ready,
  output logic [7:0]        i2c_data_out,
  output logic              i2c_data_out_valid,
  output logic              i2c_data_out_last,
  input  logic              i2c_data_out_ready,
  input  logic              i2c_bus_busy,
  input  logic              i2c_bus_control,
  input  logic              i2c_bus_active,
  input  logic              i2c_missed_ack
);

  localparam logic              LAST_IDX = 1'(ADDR_BYTES - 1);
  localparam logic [BCNT_W-1:0] MAX_CNT  = BCNT_W'(MAX_PAYLOAD);

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   rem_q, rem_d;
  logic [REG_W-1:0]    reg_q, reg_d;
  logic [6:0]          addr_q, addr_d;
  logic                idx_q, idx_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [6:0]          cmd_address_q, cmd_address_d;
  logic [7:0]          data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                data_last_q, data_last_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic                adv_c, cmd_hs_c, data_hs_c, counting_c, clear_c, expired;
  logic [7:0]          addr_byte_c;
  logic [CNT_W-1:0]    limit_c;

  assign cmd_hs_c   = cmd_valid_q & i2c_cmd_ready;
  assign data_hs_c  = data_valid_q & i2c_data_out_ready;
  assign counting_c = state_q inside {S_BUS_CHECK, S_CMD, S_ADDR, S_FETCH, S_SEND, S_DRAIN};
  assign clear_c    = (state_d != state_q) | adv_c | ~counting_c;
  assign limit_c    = (state_q == S_DRAIN) ? CNT_W'(DRAIN_TIMEOUT_CYCLES) : CNT_W'(TIMEOUT_CYCLES);

  i2c_timeout_ctr u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear_c),
    .limit   (limit_c),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      rem_q         <= '0;
      reg_q         <= '0;
      addr_q        <= '0;
      idx_q         <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_address_q <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      data_last_q   <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      reg_q         <= reg_d;
      addr_q        <= addr_d;
      idx_q         <= idx_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_address_q <= cmd_address_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      data_last_q   <= data_last_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
    end
  end

  // Handshakes are checked before the timeout so a late accept still succeeds.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    reg_d   = reg_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    adv_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = dev_address;
          reg_d   = reg_address;
          rem_d   = (byte_count > MAX_CNT) ? MAX_CNT : byte_count;
          idx_d   = 1'b0;
          state_d = S_BUS_CHECK;
        end
      end
      S_BUS_CHECK: begin
        if (!i2c_bus_busy && !i2c_bus_active) state_d = S_CMD;
        else if (expired)                     state_d = S_FAIL;
      end
      S_CMD: begin
        if (cmd_hs_c)     state_d = S_ADDR;
        else if (expired) state_d = S_FAIL;
      end
      S_ADDR: begin
        if (data_hs_c) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 1'b1;
            adv_c = 1'b1;
          end else begin
            state_d = (rem_q == '0) ? S_DRAIN : S_FETCH;
          end
        end else if (expired) begin
          state_d = S_FAIL;
        end
      end
      S_FETCH: begin
        if (wr_valid)     state_d = S_SEND;
        else if (expired) state_d = S_FAIL;
      end
      S_SEND: begin
        if (data_hs_c) begin
          rem_d   = rem_q - BCNT_W'(1);
          state_d = (rem_d == '0) ? S_DRAIN : S_FETCH;
        end else if (expired) begin
          state_d = S_FAIL;
        end
      end
      S_DRAIN: begin
        if (!i2c_bus_busy && !i2c_bus_control) state_d = S_DONE;
        else if (expired)                      state_d = S_FAIL;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i2c_missed_ack && (state_q != S_IDLE) && (state_q != S_FAIL)) begin
      state_d = S_FAIL;
    end
  end

  // Output registers are loaded from the next state so they track state_q exactly.
  always_comb begin
    addr_byte_c = reg_d[7:0];
`ifdef I2C_WRITE_REG16_EN
    if (!idx_d) addr_byte_c = reg_d[15:8];
`endif
    cmd_valid_d   = (state_d == S_CMD);
    cmd_address_d = addr_d;
    data_out_d    = data_out_q;
    data_valid_d  = (state_d == S_ADDR) || (state_d == S_SEND);
    data_last_d   = 1'b0;
    done_d        = (state_d == S_DONE);
    fail_d        = (state_d == S_FAIL);
    if (state_d == S_ADDR) begin
      data_out_d  = addr_byte_c;
      data_last_d = (idx_d == LAST_IDX) && (rem_d == '0);
    end else if (state_d == S_SEND) begin
      if (state_q == S_FETCH) data_out_d = wr_data;
      data_last_d = (rem_d == BCNT_W'(1));
    end
  end

  assign wr_ready               = (state_q == S_FETCH);
  assign busy                   = (state_q != S_IDLE);
  assign state_out              = state_q;
  assign done                   = done_q;
  assign message_failure        = fail_q;
  assign i2c_cmd_address        = cmd_address_q;
  assign i2c_cmd_valid          = cmd_valid_q;
  assign i2c_cmd_start          = cmd_valid_q;
  assign i2c_cmd_write_multiple = cmd_valid_q;
  assign i2c_cmd_stop           = cmd_valid_q;
  assign i2c_cmd_read           = 1'b0;
  assign i2c_cmd_write          = 1'b0;
  assign i2c_data_out           = data_out_q;
  assign i2c_data_out_valid     = data_valid_q;
  assign i2c_data_out_last      = data_last_q;

endmodule

// File: tb/tb_i2c_write_reg_burst.sv
// Self-checking bench for i2c_write_reg_burst: transaction-level byte model plus
// directed scenarios (burst, stalls, missed ack, timeouts, reset, clamp).
module tb_i2c_write_reg_burst;
  import i2c_pkg::*;

  localparam int unsigned TO  = 40;
  localparam int unsigned DTO = 120;

  logic clk = 1'b0;
  logic reset_n;
  logic start = 1'b0;
  logic [6:0] dev_address = '0;
  logic [REG_W-1:0] reg_address = '0;
  logic [4:0] byte_count = '0;
  logic [7:0] wr_data;
  logic wr_valid;
  logic wr_ready, done, busy, message_failure;
  logic [3:0] state_out;
  logic [6:0] i2c_cmd_address;
  logic i2c_cmd_start, i2c_cmd_read, i2c_cmd_write, i2c_cmd_write_multiple, i2c_cmd_stop;
  logic i2c_cmd_valid;
  logic i2c_cmd_ready = 1'b1;
  logic [7:0] i2c_data_out;
  logic i2c_data_out_valid, i2c_data_out_last;
  logic i2c_data_out_ready = 1'b1;
  logic i2c_bus_busy = 1'b0, i2c_bus_control = 1'b0, i2c_bus_active = 1'b0, i2c_missed_ack = 1'b0;

  i2c_write_reg_burst #(
    .TIMEOUT_CYCLES(TO), .DRAIN_TIMEOUT_CYCLES(DTO), .MAX_PAYLOAD(MAX_BYTES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dev_address(dev_address),
    .reg_address(reg_address), .byte_count(byte_count), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .done(done), .busy(busy),
    .message_failure(message_failure), .state_out(state_out),
    .i2c_cmd_address(i2c_cmd_address), .i2c_cmd_start(i2c_cmd_start),
    .i2c_cmd_read(i2c_cmd_read), .i2c_cmd_write(i2c_cmd_write),
    .i2c_cmd_write_multiple(i2c_cmd_write_multiple), .i2c_cmd_stop(i2c_cmd_stop),
    .i2c_cmd_valid(i2c_cmd_valid), .i2c_cmd_ready(i2c_cmd_ready),
    .i2c_data_out(i2c_data_out), .i2c_data_out_valid(i2c_data_out_valid),
    .i2c_data_out_last(i2c_data_out_last), .i2c_data_out_ready(i2c_data_out_ready),
    .i2c_bus_busy(i2c_bus_busy), .i2c_bus_control(i2c_bus_control),
    .i2c_bus_active(i2c_bus_active), .i2c_missed_ack(i2c_missed_ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected transaction model: {last, byte} in wire order, plus event logs.
  logic [8:0] exp_q[$];
  logic [8:0] sent_q[$];
  logic [7:0] payload[$];
  logic [7:0] pay_q[$];
  logic [6:0] exp_addr = '0;
  int done_cnt = 0, fail_cnt = 0, cmd_cnt = 0, data_hs = 0;
  int start_cyc = 0, fail_cyc = 0, hs_last_cyc = 0;
  int gap_cfg = 0, gap_cnt = 0;
  bit flush = 1'b0, took;
  bit prev_done = 1'b0, prev_mf = 1'b0, prev_cmd_hs = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous compare of the DUT against the model.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_done = 1'b0; prev_mf = 1'b0; prev_cmd_hs = 1'b0;
    end else begin
      chk("ready_excl", 32'(wr_ready & i2c_data_out_valid), 32'd0);
      chk("pulse_excl", 32'(done & message_failure), 32'd0);
      if (prev_cmd_hs) chk("cmd_drop", 32'(i2c_cmd_valid), 32'd0);
      prev_cmd_hs = i2c_cmd_valid && i2c_cmd_ready;
      if (prev_cmd_hs) begin
        cmd_cnt++;
        chk("cmd_fields",
            32'({i2c_cmd_address, i2c_cmd_start, i2c_cmd_read, i2c_cmd_write,
                 i2c_cmd_write_multiple, i2c_cmd_stop}),
            32'({exp_addr, 5'b10011}));
      end
      if (i2c_data_out_valid && i2c_data_out_ready) begin
        data_hs++;
        sent_q.push_back({i2c_data_out_last, i2c_data_out});
        if (i2c_data_out_last) hs_last_cyc = cyc;
        if (exp_q.size() == 0) chk("extra_byte", 32'({i2c_data_out_last, i2c_data_out}), 32'hFFFF_FFFF);
        else chk("byte", 32'({i2c_data_out_last, i2c_data_out}), 32'(exp_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        chk("done_pulse", 32'(prev_done), 32'd0);
      end
      if (message_failure) begin
        fail_cnt++;
        fail_cyc = cyc;
        chk("fail_pulse", 32'(prev_mf), 32'd0);
      end
      prev_done = done;
      prev_mf   = message_failure;
    end
  end

  // Upstream byte source with configurable gap between bytes.
  initial begin
    wr_valid = 1'b0; wr_data = '0;
    forever begin
      @(negedge clk);
      took = wr_valid && wr_ready;
      if (flush) begin
        pay_q.delete(); wr_valid = 1'b0; took = 1'b0; flush = 1'b0; gap_cnt = 0;
      end
      @(posedge clk); #1;
      if (took) begin
        void'(pay_q.pop_front());
        wr_valid = 1'b0;
        gap_cnt = gap_cfg;
      end
      if (!wr_valid && pay_q.size() > 0) begin
        if (gap_cnt > 0) gap_cnt--;
        else begin wr_valid = 1'b1; wr_data = pay_q[0]; end
      end
    end
  end

  task automatic launch(input logic [6:0] dev, input logic [REG_W-1:0] rg,
                        input logic [4:0] cnt, input int gap);
    int nb;
    nb = (int'(cnt) > int'(MAX_BYTES)) ? int'(MAX_BYTES) : int'(cnt);
    exp_addr = dev;
    for (int i = int'(ADDR_BYTES) - 1; i >= 0; i--)
      exp_q.push_back({(i == 0) && (nb == 0), 8'(rg >> (8 * i))});
    for (int i = 0; i < nb; i++) exp_q.push_back({i == nb - 1, payload[i]});
    gap_cfg = gap;
    foreach (payload[i]) pay_q.push_back(payload[i]);
    dev_address = dev; reg_address = rg; byte_count = cnt;
    start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input bit expect_ok, input int d0, input int f0);
    int n = 0;
    while (done_cnt == d0 && fail_cnt == f0 && n < 3000) begin @(posedge clk); #1; n++; end
    chk("outcome_done", 32'(done_cnt - d0), expect_ok ? 32'd1 : 32'd0);
    chk("outcome_fail", 32'(fail_cnt - f0), expect_ok ? 32'd0 : 32'd1);
    if (expect_ok) chk("all_bytes_sent", 32'(exp_q.size()), 32'd0);
    chk("idle_after", 32'({busy, state_out, wr_ready}), 32'd0);
    exp_q.delete(); flush = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input logic [6:0] dev, input logic [REG_W-1:0] rg,
                         input logic [4:0] cnt, input int gap, input bit expect_ok);
    int d0, f0;
    d0 = done_cnt; f0 = fail_cnt;
    launch(dev, rg, cnt, gap);
    wait_end(expect_ok, d0, f0);
  endtask

  task automatic wait_payload(input int target, input string name);
    int n = 0;
    while (!(data_hs == target && i2c_data_out_valid) && n < 500) begin @(posedge clk); #1; n++; end
    chk(name, 32'(n < 500), 32'd1);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({i2c_cmd_address, i2c_cmd_start, i2c_cmd_read, i2c_cmd_write,
                i2c_cmd_write_multiple, i2c_cmd_stop, i2c_cmd_valid, i2c_data_out,
                i2c_data_out_valid, i2c_data_out_last, done, busy, message_failure,
                state_out, wr_ready});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c0, inj;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", all_outs(), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single byte write to VL53L0X.
    sent_q.delete(); payload = '{8'h00};
    run_txn(VL53L0X_ADDR, REG_W'(8'h88), 5'd1, 0, 1'b1);
    chk("t1_nbytes", 32'(sent_q.size()), 32'(ADDR_BYTES + 1));
    chk("t1_reg", 32'(sent_q[ADDR_BYTES - 1]), 32'h088);
    chk("t1_data", 32'(sent_q[ADDR_BYTES]), 32'h100);

    // Gapped burst; a second start mid-transaction must be ignored.
    sent_q.delete(); payload = '{8'h11, 8'h22, 8'h33, 8'h44};
    base = data_hs; c0 = cmd_cnt;
    fork
      run_txn(7'h29, REG_W'(8'h10), 5'd4, 10, 1'b1);
      begin
        wait_payload(base + int'(ADDR_BYTES) + 1, "burst_mid");
        dev_address = 7'h11; byte_count = 5'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    chk("start_ignored", 32'(cmd_cnt - c0), 32'd1);
    chk("burst_last", 32'(sent_q[ADDR_BYTES + 3]), 32'h144);
    chk("burst_third", 32'(sent_q[ADDR_BYTES + 2]), 32'h033);

    // Address-only write.
    sent_q.delete(); payload.delete();
    run_txn(7'h52, REG_W'(8'hC0), 5'd0, 0, 1'b1);
    chk("addr_only_n", 32'(sent_q.size()), 32'(ADDR_BYTES));
    chk("addr_only_last", 32'(sent_q[ADDR_BYTES - 1]), 32'h1C0);

    // Oversized byte_count is clamped.
    sent_q.delete(); payload.delete();
    for (int i = 0; i < 20; i++) payload.push_back(8'(3 * i + 1));
    run_txn(7'h29, REG_W'(8'h01), 5'd20, 0, 1'b1);
    chk("clamp_n", 32'(sent_q.size()), 32'(ADDR_BYTES + 16));
    chk("clamp_last", 32'(sent_q[ADDR_BYTES + 15]), 32'h12E);

    // Missed ack during the second payload byte.
    payload = '{8'hA1, 8'hA2, 8'hA3};
    base = data_hs; inj = 0;
    fork
      run_txn(7'h29, REG_W'(8'h20), 5'd3, 0, 1'b0);
      begin
        wait_payload(base + int'(ADDR_BYTES) + 1, "mack_reach");
        i2c_missed_ack = 1'b1; inj = cyc;
        @(posedge clk); #1;
        i2c_missed_ack = 1'b0;
      end
    join
    chk("mack_latency", 32'(fail_cyc - inj), 32'd1);

    // Bus stays active: timeout in the bus check.
    payload = '{8'h55};
    c0 = cmd_cnt;
    i2c_bus_active = 1'b1;
    run_txn(7'h29, REG_W'(8'h30), 5'd1, 0, 1'b0);
    i2c_bus_active = 1'b0;
    chk("bus_to_latency", 32'(fail_cyc - start_cyc), 32'(TO + 1));
    chk("bus_to_nocmd", 32'(cmd_cnt - c0), 32'd0);

    // Bus control never released after the final byte.
    payload = '{8'h66, 8'h77};
    i2c_bus_control = 1'b1;
    run_txn(7'h29, REG_W'(8'h40), 5'd2, 0, 1'b0);
    i2c_bus_control = 1'b0;
    chk("drain_to_latency", 32'(fail_cyc - hs_last_cyc), 32'(DTO + 1));

    // Reset in the middle of a payload byte, then a clean transaction.
    payload = '{8'h01, 8'h02, 8'h03};
    base = data_hs;
    launch(7'h29, REG_W'(8'h50), 5'd3, 0);
    wait_payload(base + int'(ADDR_BYTES) + 1, "rst_reach");
    reset_n = 1'b0;
    #1 chk("reset_mid_outputs", all_outs(), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_q.delete(); flush = 1'b1;
    @(posedge clk); #1;
    sent_q.delete(); payload = '{8'h9A};
    run_txn(7'h29, REG_W'(8'h60), 5'd1, 0, 1'b1);
    chk("post_reset_data", 32'(sent_q[ADDR_BYTES]), 32'h19A);

`ifdef I2C_WRITE_REG16_EN
    sent_q.delete(); payload.delete();
    run_txn(7'h29, 16'h0123, 5'd0, 0, 1'b1);
    chk("reg16_msb", 32'(sent_q[0]), 32'h001);
    chk("reg16_lsb", 32'(sent_q[1]), 32'h123);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
